// File: rtl/spw_rx_credit_fifo.sv
// SpaceWire receive buffer: show-ahead character FIFO plus FCT credit accounting.
// Grants credit in units of 8 only when every granted character is sure to have a slot.
module spw_rx_credit_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          rx_clk,
  input  logic          rx_reset,
  input  logic          link_run,
  input  logic [8:0]    rx_data_flag,
  input  logic          rx_buffer_write,
  input  logic          fct_ack,
  input  logic          rd_ready,
  output logic [8:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   fifo_count,
  output logic [5:0]    outstanding,
  output logic          fct_req,
  output logic          credit_error
);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [5:0]    r_outst;
  logic          r_link;
  logic          r_cerr;

  logic          w_full;
  logic          w_wr_ok;
  logic          w_wr_bad;
  logic          w_rd;
  logic          w_ack;
  logic [AW+1:0] w_free;
  logic [AW+1:0] w_need;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_wr_ok  = rx_buffer_write && (r_outst != 6'd0) && !w_full;
  assign w_wr_bad = rx_buffer_write && !w_wr_ok;
  assign w_rd     = (r_count != '0) && rd_ready;

  // Link state is taken from the register so fct_req is purely a function of registered state
  assign w_free  = (AW+2)'(DEPTH) - {1'b0, r_count};
  assign w_need  = (AW+2)'(r_outst) + (AW+2)'(8);
  assign fct_req = r_link && (r_outst <= 6'd48) && (w_free >= w_need);
  assign w_ack   = fct_ack && fct_req;

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_outst <= '0;
      r_link  <= 1'b0;
      r_cerr  <= 1'b0;
    end else begin
      r_link <= link_run;
      r_cerr <= w_wr_bad;
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_ok, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (!link_run)
        r_outst <= '0;
      else
        r_outst <= r_outst + (w_ack ? 6'd8 : 6'd0) - (w_wr_ok ? 6'd1 : 6'd0);
    end
  end

  always_ff @(posedge rx_clk) begin
    if (w_wr_ok && !rx_reset) r_mem[r_wptr] <= rx_data_flag;
  end

  // Storage is not cleared on reset; the head is masked while empty instead
  assign rd_valid     = (r_count != '0);
  assign rd_data      = rd_valid ? r_mem[r_rptr] : 9'd0;
  assign fifo_count   = r_count;
  assign outstanding  = r_outst;
  assign credit_error = r_cerr;

endmodule
